// File: rtl/uart_boot_loader_pkg.sv
// Shared constants for the UART boot loader: the sync byte, the loader FSM
// encodings and the word-to-byte-address helper.
package uart_boot_loader_pkg;

    localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] CSUM  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERROR = 3'd5;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, byte_valid pulse
// on a good stop bit and frame_err pulse on a bad one.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]       rx_state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    assign byte_data = shift_reg;

    // NOTE: every register here uses non-blocking assignment so each one
    // samples pre-edge values; blocking would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        clk_cnt  <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: receives an A5/LEN/DATA/CSUM frame over UART, writes
// little-endian words to memory and raises loading_done on a good checksum.
module uart_boot_loader #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        loading_done,
    output logic        load_error,
    output logic [31:0] words_loaded
);

    import uart_boot_loader_pkg::*;

    localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    logic [2:0]       state;
    logic [31:0]      len;
    logic [1:0]       byte_cnt;
    logic [23:0]      word_buf;
    logic [IDX_W-1:0] idx;
    logic [7:0]       xor_acc;
    logic [TMO_W-1:0] tmo_cnt;

    logic [31:0] len_next;
    logic        in_frame;
    logic        abort;
    logic        last_word;

    // LEN is checked in full 32 bits, before anything narrows it.
    assign len_next  = {byte_data, len[31:8]};
    assign in_frame  = (state == LEN) || (state == DATA) || (state == CSUM);
    assign abort     = frame_err || (!byte_valid && tmo_cnt == TMO_LAST);
    assign last_word = (32'(idx) + 32'd1) == len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len          <= '0;
            byte_cnt     <= '0;
            word_buf     <= '0;
            idx          <= '0;
            xor_acc      <= '0;
            tmo_cnt      <= '0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            loading_done <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (in_frame) tmo_cnt <= byte_valid ? '0 : tmo_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (byte_valid && byte_data == BOOT_SYNC_BYTE) begin
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        xor_acc      <= '0;
                        idx          <= '0;
                        byte_cnt     <= '0;
                        tmo_cnt      <= '0;
                        state        <= LEN;
                    end
                end
                LEN: begin
                    if (abort) begin
                        state <= ERROR;
                    end else if (byte_valid) begin
                        len      <= len_next;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            if (len_next > 32'(MAX_WORDS)) state <= ERROR;
                            else if (len_next == 32'd0)    state <= CSUM;
                            else                           state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (abort) begin
                        state <= ERROR;
                    end else if (byte_valid) begin
                        word_buf <= {byte_data, word_buf[23:8]};
                        xor_acc  <= xor_acc ^ byte_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= word_addr(BASE_ADDR, 32'(idx));
                            mem_wdata    <= {byte_data, word_buf};
                            idx          <= idx + 1'b1;
                            words_loaded <= words_loaded + 32'd1;
                            if (last_word) state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (abort) begin
                        state <= ERROR;
                    end else if (byte_valid) begin
                        if (byte_data == xor_acc) begin
                            loading_done <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                DONE: loading_done <= 1'b1;
                ERROR: begin
                    load_error <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of frames with expected
// outcomes, a write scoreboard, and hand-written multi-cycle corner cases.
module tb_uart_boot_loader;

    localparam int unsigned CPB   = 16;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int unsigned MAXW  = 16384;
    localparam int unsigned TMO   = 400;
    localparam int          NV    = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        loading_done;
    logic        load_error;
    logic [31:0] words_loaded;

    uart_boot_loader #(
        .CLKS_PER_BIT  (CPB),
        .BASE_ADDR     (BASE),
        .MAX_WORDS     (MAXW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .loading_done(loading_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int n;
        int sp;
        int exp_writes;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vecs[NV];
    logic [7:0] frames[NV][16];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       we_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", mem_wdata, e.data);
            end
            check("we_single_cycle", {31'b0, we_prev}, 32'd0);
        end
        we_prev = rst_n && mem_we;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) begin
            uart_rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Sends bytes [first, last) of frame v, queuing each expected write
    // just before the byte that completes its word.
    task automatic send_frame(input int v, input int first, input int last, input bit do_push);
        int  j;
        wr_t e;
        for (int k = first; k < last; k++) begin
            j = k - vecs[v].sp - 5;
            if (do_push && j >= 0 && j % 4 == 3 && j / 4 < vecs[v].exp_writes) begin
                e.addr = BASE + 32'(4 * (j / 4));
                e.data = {frames[v][k], frames[v][k-1], frames[v][k-2], frames[v][k-3]};
                exp_q.push_back(e);
            end
            send_byte(frames[v][k], 1'b1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input bit done, input bit err, input int words);
        check({tag, "_done"}, {31'b0, loading_done}, {31'b0, done});
        check({tag, "_err"}, {31'b0, load_error}, {31'b0, err});
        check({tag, "_words"}, words_loaded, 32'(words));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, mem_addr, BASE);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_done"}, {31'b0, loading_done}, 32'd0);
        check({tag, "_err"}, {31'b0, load_error}, 32'd0);
        check({tag, "_words"}, words_loaded, 32'd0);
    endtask

    initial begin
        frames[0] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00,
                      8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'h00, 8'h00};
        frames[1] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00,
                      8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91, 8'h00, 8'h00};
        frames[2] = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frames[3] = '{8'hA5, 8'h01, 8'h40, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frames[4] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h80, 8'h13, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frames[5] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22,
                      8'h11, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frames[6] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        //            n   sp writes done  err   words
        vecs[0] = '{14, 0, 2, 1'b1, 1'b0, 2};   // good 2-word image
        vecs[1] = '{14, 0, 2, 1'b0, 1'b1, 2};   // bad checksum after 2 writes
        vecs[2] = '{ 9, 3, 0, 1'b1, 1'b0, 0};   // noise then empty image
        vecs[3] = '{ 9, 0, 0, 1'b0, 1'b1, 0};   // LEN = MAX_WORDS + 1
        vecs[4] = '{ 9, 0, 0, 1'b0, 1'b1, 0};   // LEN with bit 31 set
        vecs[5] = '{10, 0, 1, 1'b1, 1'b0, 1};   // byte order within a word
        vecs[6] = '{ 6, 0, 0, 1'b0, 1'b1, 0};   // empty image, checksum != 0

        do_reset();
        check_reset_values("reset");

        for (int v = 0; v < NV; v++) begin
            do_reset();
            send_frame(v, 0, vecs[v].n, 1'b1);
            check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_words);
        end

        // Once done, further frames are ignored.
        do_reset();
        send_frame(0, 0, 14, 1'b1);
        send_frame(5, 0, 10, 1'b0);
        check_status("after_done", 1'b1, 1'b0, 2);

        // Bad frame, then retransmission: error clears on the sync byte.
        do_reset();
        send_frame(1, 0, 14, 1'b1);
        check_status("retx_bad", 1'b0, 1'b1, 2);
        send_frame(0, 0, 1, 1'b1);
        check("retx_err_cleared_on_sync", {31'b0, load_error}, 32'd0);
        send_frame(0, 1, 14, 1'b1);
        check_status("retx_good", 1'b1, 1'b0, 2);

        // Idle gap shorter than the timeout is tolerated.
        do_reset();
        send_frame(0, 0, 7, 1'b1);
        repeat (200) @(negedge clk);
        send_frame(0, 7, 14, 1'b1);
        check_status("slow_host", 1'b1, 1'b0, 2);

        // Timeout after the 2nd data byte, then recovery from IDLE.
        do_reset();
        send_frame(0, 0, 7, 1'b1);
        repeat (TMO + 20) @(negedge clk);
        check_status("timeout", 1'b0, 1'b1, 0);
        send_frame(0, 0, 14, 1'b1);
        check_status("timeout_recover", 1'b1, 1'b0, 2);

        // Framing error mid-word aborts without a partial write.
        do_reset();
        send_frame(0, 0, 7, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check_status("frame_err", 1'b0, 1'b1, 0);
        send_frame(0, 0, 14, 1'b1);
        check_status("frame_err_recover", 1'b1, 1'b0, 2);

        // A short low glitch on an idle line produces no byte.
        do_reset();
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(5, 0, 10, 1'b1);
        check_status("glitch", 1'b1, 1'b0, 1);

        // Reset during DATA after one word, then a clean reload.
        do_reset();
        send_frame(0, 0, 10, 1'b1);
        check("midreset_words_before", words_loaded, 32'd1);
        #3 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(0, 0, 14, 1'b1);
        check_status("midreset_reload", 1'b1, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
